// File: rtl/router_pkg.sv
// router_pkg: default link/packet widths, phit/packet types, TX FSM state
// encoding and a phit-XOR checksum helper shared by the node endpoint.
package router_pkg;
    localparam int PKT_W_DEF  = 32;
    localparam int PHIT_W_DEF = 8;
    localparam int BEATS_DEF  = PKT_W_DEF / PHIT_W_DEF;

    typedef logic [PHIT_W_DEF-1:0] phit_t;
    typedef logic [PKT_W_DEF-1:0]  pkt_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    // XOR of every phit of a default-width packet
    function automatic phit_t cksum(input pkt_t pkt);
        phit_t acc;
        acc = '0;
        for (int i = 0; i < BEATS_DEF; i++) begin
            acc ^= pkt[i*PHIT_W_DEF +: PHIT_W_DEF];
        end
        return acc;
    endfunction
endpackage

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-wide circular FIFO. Writes while full and reads while
// empty are ignored; data_out shows the head entry and reads as zero when empty.
module pkt_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PKT_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd,
    output logic [W-1:0]           data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_wr;
    logic          do_rd;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_wr    = wr && !full;
    assign do_rd    = rd && !empty;
    assign data_out = empty ? '0 : mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_wr && !do_rd) begin
                count_reg <= count_reg + CW'(1);
            end else if (!do_wr && do_rd) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end
endmodule

// File: rtl/node_endpoint.sv
// node_endpoint: network-interface node. Outbound packets are queued and
// serialised MSB phit first; inbound phits are reassembled and queued with
// valid/ready toward the packet side.
// Optional build macro NODE_CKSUM_EN appends/verifies one XOR checksum phit
// per packet and drives rx_err on an inbound mismatch.
module node_endpoint
    import router_pkg::*;
#(
    parameter int NODEID   = 0,
    parameter int PKT_W    = PKT_W_DEF,
    parameter int PHIT_W   = PHIT_W_DEF,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    input  logic              pkt_out_ready,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [PHIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [PHIT_W-1:0] payload_inbound,
    output logic              rx_err
);
    localparam int BEATS = PKT_W / PHIT_W;
`ifdef NODE_CKSUM_EN
    localparam int PHITS = BEATS + 1;
`else
    localparam int PHITS = BEATS;
`endif
    localparam int BW    = $clog2(PHITS + 1);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    // The node identifier is informational only
    logic nodeid_unused;
    assign nodeid_unused = (NODEID != 0);

    // ---------------- outbound ----------------
    tx_state_t         state_reg, state_next;
    logic [PKT_W-1:0]  tx_shift_reg, tx_shift_next;
    logic [BW-1:0]     tx_beat_reg, tx_beat_next;
    logic [PKT_W-1:0]  tx_head;
    logic              tx_pop;
    logic              tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count_unused;
`ifdef NODE_CKSUM_EN
    logic [PHIT_W-1:0] tx_cks_reg, tx_cks_next;
`endif

    pkt_fifo #(.DEPTH(TX_DEPTH), .W(PKT_W)) u_tx_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr       (pkt_in_avail),
        .wr_data  (pkt_in),
        .rd       (tx_pop),
        .data_out (tx_head),
        .full     (cQ_full),
        .empty    (tx_empty),
        .count    (tx_count_unused)
    );

    // TX FSM state, shift register and beat counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_beat_reg  <= '0;
`ifdef NODE_CKSUM_EN
            tx_cks_reg   <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            tx_shift_reg <= tx_shift_next;
            tx_beat_reg  <= tx_beat_next;
`ifdef NODE_CKSUM_EN
            tx_cks_reg   <= tx_cks_next;
`endif
        end
    end

    // TX next-state: free_outbound only matters in IDLE; a started packet always completes
    always_comb begin
        state_next       = state_reg;
        tx_shift_next    = tx_shift_reg;
        tx_beat_next     = tx_beat_reg;
        tx_pop           = 1'b0;
        put_outbound     = 1'b0;
        payload_outbound = '0;
`ifdef NODE_CKSUM_EN
        tx_cks_next      = tx_cks_reg;
`endif
        case (state_reg)
            TX_IDLE: begin
                if (!tx_empty && free_outbound) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_head;
                    tx_beat_next  = '0;
`ifdef NODE_CKSUM_EN
                    tx_cks_next   = '0;
`endif
                    state_next    = TX_SEND;
                end
            end
            TX_SEND: begin
                put_outbound = 1'b1;
                tx_beat_next = tx_beat_reg + BW'(1);
                if (tx_beat_reg < BW'(BEATS)) begin
                    payload_outbound = tx_shift_reg[PKT_W-1 -: PHIT_W];
                    tx_shift_next    = tx_shift_reg << PHIT_W;
`ifdef NODE_CKSUM_EN
                    tx_cks_next      = tx_cks_reg ^ tx_shift_reg[PKT_W-1 -: PHIT_W];
                end else begin
                    payload_outbound = tx_cks_reg;
`endif
                end
                if (tx_beat_reg == BW'(PHITS - 1)) state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // ---------------- inbound ----------------
    logic              rx_busy_reg, rx_busy_next;
    logic [BW-1:0]     rx_beat_reg, rx_beat_next;
    logic [PKT_W-1:0]  rx_asm_reg, rx_asm_next;
    logic [PKT_W-1:0]  rx_push_data;
    logic              rx_push;
    logic              rx_accept;
    logic              rx_empty;
    logic              rx_full_unused;
    logic [RX_CW-1:0]  rx_count;
`ifdef NODE_CKSUM_EN
    logic [PHIT_W-1:0] rx_cks_reg, rx_cks_next;
    logic              rx_err_reg, rx_err_next;
`endif

    pkt_fifo #(.DEPTH(RX_DEPTH), .W(PKT_W)) u_rx_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr       (rx_push),
        .wr_data  (rx_push_data),
        .rd       (pkt_out_ready),
        .data_out (pkt_out),
        .full     (rx_full_unused),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign pkt_out_avail = !rx_empty;
    // Room is checked only at packet start: the FIFO cannot fill mid-packet
    assign free_inbound  = rx_busy_reg || (rx_count < RX_CW'(RX_DEPTH));
    assign rx_accept     = put_inbound && free_inbound;

    // RX assembler registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_busy_reg <= 1'b0;
            rx_beat_reg <= '0;
            rx_asm_reg  <= '0;
`ifdef NODE_CKSUM_EN
            rx_cks_reg  <= '0;
            rx_err_reg  <= 1'b0;
`endif
        end else begin
            rx_busy_reg <= rx_busy_next;
            rx_beat_reg <= rx_beat_next;
            rx_asm_reg  <= rx_asm_next;
`ifdef NODE_CKSUM_EN
            rx_cks_reg  <= rx_cks_next;
            rx_err_reg  <= rx_err_next;
`endif
        end
    end

    // RX assembly: shift accepted phits in, push on the final phit of a packet
    always_comb begin
        rx_busy_next = rx_busy_reg;
        rx_beat_next = rx_beat_reg;
        rx_asm_next  = rx_asm_reg;
        rx_push      = 1'b0;
        rx_push_data = rx_asm_reg;
`ifdef NODE_CKSUM_EN
        rx_cks_next  = rx_cks_reg;
        rx_err_next  = 1'b0;
`endif
        if (rx_accept) begin
            if (rx_beat_reg < BW'(BEATS)) begin
                rx_asm_next = (rx_asm_reg << PHIT_W) | PKT_W'(payload_inbound);
`ifdef NODE_CKSUM_EN
                rx_cks_next = rx_cks_reg ^ payload_inbound;
`endif
            end
            if (rx_beat_reg == BW'(PHITS - 1)) begin
                rx_busy_next = 1'b0;
                rx_beat_next = '0;
`ifdef NODE_CKSUM_EN
                rx_cks_next  = '0;
                rx_push_data = rx_asm_reg;
                if (payload_inbound == rx_cks_reg) begin
                    rx_push = 1'b1;
                end else begin
                    rx_err_next = 1'b1;
                end
`else
                rx_push      = 1'b1;
                rx_push_data = rx_asm_next;
`endif
            end else begin
                rx_busy_next = 1'b1;
                rx_beat_next = rx_beat_reg + BW'(1);
            end
        end
    end

`ifdef NODE_CKSUM_EN
    assign rx_err = rx_err_reg;
`else
    assign rx_err = 1'b0;
`endif
endmodule

// File: tb/tb_node_endpoint.sv
// tb_node_endpoint: table-driven vectors plus directed multi-cycle sequences;
// a negedge monitor pops expected phits/packets from scoreboard queues.
// Build with +define+NODE_CKSUM_EN to exercise the checksum variant.
`timescale 1ns/1ps
module tb_node_endpoint;
    localparam int BEATS = 4;
`ifdef NODE_CKSUM_EN
    localparam int PHITS = BEATS + 1;
`else
    localparam int PHITS = BEATS;
`endif

    logic        clock;
    logic        reset_n;
    logic [31:0] pkt_in;
    logic        pkt_in_avail;
    logic        cQ_full;
    logic [31:0] pkt_out;
    logic        pkt_out_avail;
    logic        pkt_out_ready;
    logic        free_outbound;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound;
    logic [7:0]  payload_inbound;
    logic        rx_err;

    int n_vec = 0;
    int n_err = 0;
    int tx_run = 0;
    logic [7:0]  exp_phit[$];
    logic [31:0] exp_pkt[$];

    typedef struct {
        logic [31:0] pkt;
        logic [7:0]  ph0, ph1, ph2, ph3;
    } tx_vec_t;
    typedef struct {
        logic [7:0]  ph0, ph1, ph2, ph3;
        logic [31:0] pkt;
    } rx_vec_t;
    tx_vec_t     tx_tab[5];
    rx_vec_t     rx_tab[4];
    logic [31:0] ovf[5];

    node_endpoint #(
        .NODEID(3), .PKT_W(32), .PHIT_W(8), .TX_DEPTH(4), .RX_DEPTH(2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pkt_in           (pkt_in),
        .pkt_in_avail     (pkt_in_avail),
        .cQ_full          (cQ_full),
        .pkt_out          (pkt_out),
        .pkt_out_avail    (pkt_out_avail),
        .pkt_out_ready    (pkt_out_ready),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .rx_err           (rx_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every outbound phit and every RX handshake is checked
    always @(negedge clock) begin
        if (!reset_n) begin
            tx_run = 0;
        end else begin
            if (put_outbound) begin
                tx_run++;
                if (exp_phit.size() == 0) check("tx_unexpected_put", 32'(put_outbound), 32'd0);
                else check("tx_phit", 32'(payload_outbound), 32'(exp_phit.pop_front()));
            end else begin
                check("tx_idle_payload", 32'(payload_outbound), 32'd0);
                if (tx_run != 0) begin
                    check("tx_burst_len", 32'(tx_run), 32'(PHITS));
                    tx_run = 0;
                end
            end
            if (pkt_out_avail && pkt_out_ready) begin
                if (exp_pkt.size() == 0) check("rx_unexpected_pkt", 32'(pkt_out_avail), 32'd0);
                else check("rx_pkt", pkt_out, exp_pkt.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        exp_phit.push_back(a);
        exp_phit.push_back(b);
        exp_phit.push_back(c);
        exp_phit.push_back(d);
`ifdef NODE_CKSUM_EN
        exp_phit.push_back(a ^ b ^ c ^ d);
`endif
    endtask

    task automatic write_pkt(input logic [31:0] p);
        pkt_in       = p;
        pkt_in_avail = 1'b1;
        step();
        pkt_in_avail = 1'b0;
        pkt_in       = '0;
    endtask

    task automatic drive_phit(input logic [7:0] p);
        put_inbound     = 1'b1;
        payload_inbound = p;
        step();
        put_inbound     = 1'b0;
        payload_inbound = '0;
    endtask

    task automatic send_rx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        drive_phit(a);
        drive_phit(b);
        drive_phit(c);
        drive_phit(d);
`ifdef NODE_CKSUM_EN
        drive_phit(a ^ b ^ c ^ d);
`endif
    endtask

    task automatic wait_tx_drain();
        int n = 0;
        while ((exp_phit.size() != 0 || put_outbound) && n < 300) begin
            step();
            n++;
        end
        n_vec++;
        if (n >= 300) begin
            n_err++;
            $display("FAIL tx_drain: %0d phits pending after %0d cycles, expected 0", exp_phit.size(), n);
        end
    endtask

    task automatic wait_not_full();
        int n = 0;
        while (cQ_full && n < 60) begin
            step();
            n++;
        end
        n_vec++;
        if (n >= 60) begin
            n_err++;
            $display("FAIL cq_full_stuck: cQ_full still 1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_tab[0] = '{pkt:32'hDEADBEEF, ph0:8'hDE, ph1:8'hAD, ph2:8'hBE, ph3:8'hEF};
        tx_tab[1] = '{pkt:32'h01234567, ph0:8'h01, ph1:8'h23, ph2:8'h45, ph3:8'h67};
        tx_tab[2] = '{pkt:32'hA5C30FF0, ph0:8'hA5, ph1:8'hC3, ph2:8'h0F, ph3:8'hF0};
        tx_tab[3] = '{pkt:32'hFFFFFFFF, ph0:8'hFF, ph1:8'hFF, ph2:8'hFF, ph3:8'hFF};
        tx_tab[4] = '{pkt:32'h00000001, ph0:8'h00, ph1:8'h00, ph2:8'h00, ph3:8'h01};
        rx_tab[0] = '{ph0:8'hCA, ph1:8'hFE, ph2:8'hBA, ph3:8'hBE, pkt:32'hCAFEBABE};
        rx_tab[1] = '{ph0:8'h00, ph1:8'hFF, ph2:8'h00, ph3:8'hFF, pkt:32'h00FF00FF};
        rx_tab[2] = '{ph0:8'h80, ph1:8'h01, ph2:8'h7F, ph3:8'hFE, pkt:32'h80017FFE};
        rx_tab[3] = '{ph0:8'h5A, ph1:8'h00, ph2:8'h00, ph3:8'hA5, pkt:32'h5A0000A5};
        ovf[0] = 32'h10203040;
        ovf[1] = 32'h50607080;
        ovf[2] = 32'h90A0B0C0;
        ovf[3] = 32'hD0E0F001;
        ovf[4] = 32'hEEEEEEEE;

        reset_n = 1'b0; pkt_in = '0; pkt_in_avail = 1'b0; pkt_out_ready = 1'b0;
        free_outbound = 1'b0; put_inbound = 1'b0; payload_inbound = '0;
        step();
        check("rst_cq_full", 32'(cQ_full), 32'd0);
        check("rst_pkt_out_avail", 32'(pkt_out_avail), 32'd0);
        check("rst_pkt_out", pkt_out, 32'd0);
        check("rst_put_outbound", 32'(put_outbound), 32'd0);
        check("rst_payload_outbound", 32'(payload_outbound), 32'd0);
        check("rst_free_inbound", 32'(free_inbound), 32'd1);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Single packet: one idle cycle after the write, then phits; free drop mid-send ignored
        free_outbound = 1'b1;
        push_tx(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        write_pkt(32'hDEADBEEF);
        check("tx_latency_idle", 32'(put_outbound), 32'd0);
        step();
        check("tx_latency_send", 32'(put_outbound), 32'd1);
        free_outbound = 1'b0;
        wait_tx_drain();
        free_outbound = 1'b1;

        // TX table: serialisation order across several patterns
        for (int i = 0; i < 5; i++) begin
            wait_not_full();
            push_tx(tx_tab[i].ph0, tx_tab[i].ph1, tx_tab[i].ph2, tx_tab[i].ph3);
            write_pkt(tx_tab[i].pkt);
        end
        wait_tx_drain();

        // Overflow: cQ_full after the 4th write, 5th write dropped
        free_outbound = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            pkt_in       = ovf[k];
            pkt_in_avail = 1'b1;
            if (k < 4) push_tx(ovf[k][31:24], ovf[k][23:16], ovf[k][15:8], ovf[k][7:0]);
            step();
            check("cq_full_after_write", 32'(cQ_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        pkt_in_avail = 1'b0;
        pkt_in       = '0;
        free_outbound = 1'b1;
        wait_tx_drain();
        repeat (12) step();
        check("cq_full_drained", 32'(cQ_full), 32'd0);

        // Inbound: avail the cycle after the last phit, head held while not ready
        pkt_out_ready = 1'b0;
        check("rx_idle_avail", 32'(pkt_out_avail), 32'd0);
        drive_phit(8'h12);
        drive_phit(8'h34);
        drive_phit(8'h56);
`ifdef NODE_CKSUM_EN
        drive_phit(8'h78);
        check("rx_avail_early", 32'(pkt_out_avail), 32'd0);
        drive_phit(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`else
        check("rx_avail_early", 32'(pkt_out_avail), 32'd0);
        drive_phit(8'h78);
`endif
        check("rx_avail_next", 32'(pkt_out_avail), 32'd1);
        check("rx_pkt_value", pkt_out, 32'h12345678);
        check("rx_free_one_held", 32'(free_inbound), 32'd1);
        repeat (3) step();
        check("rx_hold_avail", 32'(pkt_out_avail), 32'd1);
        check("rx_hold_value", pkt_out, 32'h12345678);
        check("rx_err_quiet", 32'(rx_err), 32'd0);
        exp_pkt.push_back(32'h12345678);
        pkt_out_ready = 1'b1;
        step();
        pkt_out_ready = 1'b0;
        check("rx_after_pop_avail", 32'(pkt_out_avail), 32'd0);
        check("rx_after_pop_data", pkt_out, 32'd0);

        // RX table: back-to-back packets with the consumer always ready
        pkt_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pkt.push_back(rx_tab[i].pkt);
            send_rx(rx_tab[i].ph0, rx_tab[i].ph1, rx_tab[i].ph2, rx_tab[i].ph3);
        end
        repeat (3) step();
        check("rx_table_drained", 32'(exp_pkt.size()), 32'd0);

        // Backpressure: RX full after two packets, third dropped, one pop reopens
        pkt_out_ready = 1'b0;
        send_rx(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        check("bp_free_after_1", 32'(free_inbound), 32'd1);
        send_rx(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        check("bp_free_after_2", 32'(free_inbound), 32'd0);
        send_rx(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        check("bp_head_kept", pkt_out, 32'hA1A2A3A4);
        check("bp_free_still_0", 32'(free_inbound), 32'd0);
        exp_pkt.push_back(32'hA1A2A3A4);
        exp_pkt.push_back(32'hB1B2B3B4);
        pkt_out_ready = 1'b1;
        step();
        pkt_out_ready = 1'b0;
        check("bp_free_reopen", 32'(free_inbound), 32'd1);
        check("bp_second_head", pkt_out, 32'hB1B2B3B4);
        pkt_out_ready = 1'b1;
        step();
        pkt_out_ready = 1'b0;
        check("bp_third_dropped", 32'(pkt_out_avail), 32'd0);
        check("bp_scoreboard", 32'(exp_pkt.size()), 32'd0);

        // Reset on the 2nd outbound phit, with a partial inbound packet pending
        pkt_out_ready = 1'b1;
        free_outbound = 1'b1;
        drive_phit(8'h99);
        drive_phit(8'h88);
        push_tx(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        write_pkt(32'hAABBCCDD);
        write_pkt(32'h01020304);
        check("abort_first_phit", 32'(put_outbound), 32'd1);
        step();
        check("abort_second_phit", 32'(payload_outbound), 32'h000000BB);
        reset_n = 1'b0;
        step();
        check("abort_put_low", 32'(put_outbound), 32'd0);
        check("abort_payload_zero", 32'(payload_outbound), 32'd0);
        check("abort_cq_full", 32'(cQ_full), 32'd0);
        check("abort_rx_empty", 32'(pkt_out_avail), 32'd0);
        check("abort_free_inbound", 32'(free_inbound), 32'd1);
        reset_n = 1'b1;
        exp_phit.delete();
        repeat (12) step();
        exp_pkt.push_back(32'h11223344);
        send_rx(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) step();
        check("abort_rx_clean_pkt", 32'(exp_pkt.size()), 32'd0);
        check("abort_rx_idle", 32'(pkt_out_avail), 32'd0);

`ifdef NODE_CKSUM_EN
        // Checksum: good XOR delivered, bad XOR dropped with an rx_err pulse
        pkt_out_ready = 1'b1;
        exp_pkt.push_back(32'h11223344);
        drive_phit(8'h11);
        drive_phit(8'h22);
        drive_phit(8'h33);
        drive_phit(8'h44);
        drive_phit(8'h44);
        check("cks_good_no_err", 32'(rx_err), 32'd0);
        step();
        check("cks_good_delivered", 32'(exp_pkt.size()), 32'd0);
        drive_phit(8'h11);
        drive_phit(8'h22);
        drive_phit(8'h33);
        drive_phit(8'h44);
        drive_phit(8'h00);
        check("cks_bad_err_pulse", 32'(rx_err), 32'd1);
        check("cks_bad_not_pushed", 32'(pkt_out_avail), 32'd0);
        step();
        check("cks_err_one_cycle", 32'(rx_err), 32'd0);
        check("cks_bad_still_empty", 32'(pkt_out_avail), 32'd0);
`endif

        check("tx_scoreboard_empty", 32'(exp_phit.size()), 32'd0);
        check("rx_scoreboard_empty", 32'(exp_pkt.size()), 32'd0);
        check("rx_err_final", 32'(rx_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
